// File: rtl/vmx_pkg.sv
// Shared constants for the matrix-engine memory buffer:
// host address map, FSM encoding and CTRL/STATUS bit positions.
package vmx_pkg;

    localparam logic [10:0] OPRAM_LAST  = 11'h1FF;
    localparam logic [10:0] CTRL_ADDR   = 11'h200;
    localparam logic [10:0] STATUS_ADDR = 11'h201;
    localparam logic [10:0] CYCLES_ADDR = 11'h202;
    localparam logic [10:0] RESRAM_BASE = 11'h400;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_SIMD  = 1;
    localparam int CTRL_CLR   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TMO     = 2;
    localparam int STAT_REJ     = 3;
    localparam int STAT_FSM_LSB = 8;

    localparam logic [31:0] ENG_FLAG_IDLE = 32'd0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       timeout_err;
        logic       wr_reject_err;
        logic [1:0] state;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY] = s.busy;
        w[STAT_DONE] = s.done;
        w[STAT_TMO]  = s.timeout_err;
        w[STAT_REJ]  = s.wr_reject_err;
        w[STAT_FSM_LSB +: 3] = {1'b0, s.state};
        return w;
    endfunction

endpackage

// File: rtl/vmx_sdp_ram.sv
// Simple dual-port RAM: lane-masked write port, registered
// read port with read-first behaviour on same-address collisions.
module vmx_sdp_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    parameter int LANES = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [LANES-1:0] we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int LW = WIDTH / LANES;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we[l]) begin
                mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vmx_mm_buffer.sv
// Local memory responder for the matrix engine: operand/result RAMs,
// host register bus and the start/complete launch handshake.
module vmx_mm_buffer
    import vmx_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int OP_WIDTH       = 64,
    parameter int RES_WIDTH      = 128,
    parameter int HADDR_WIDTH    = 11,
    parameter int LAUNCH_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  eng_addr,
    input  logic                   eng_wr_en,
    input  logic [RES_WIDTH-1:0]   eng_res,
    output logic [OP_WIDTH-1:0]    eng_op,
    output logic [31:0]            eng_ctrl,
    input  logic [31:0]            eng_flag,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic                   host_we,
    input  logic [HADDR_WIDTH-1:0] host_addr,
    input  logic [31:0]            host_wdata,
    output logic                   host_rvalid,
    input  logic                   host_rready,
    output logic [31:0]            host_rdata
);

    localparam int OP_LANES  = OP_WIDTH / 32;
    localparam int RES_LANES = RES_WIDTH / 32;
    localparam int TW        = $clog2(LAUNCH_TIMEOUT + 1);

    logic [1:0]          state;
    logic                simd_q;
    logic                done_q;
    logic                tmo_q;
    logic                rej_q;
    logic [31:0]         cycles;
    logic [TW-1:0]       lcnt;
    logic                busy;

    logic                host_acc;
    logic                wr_acc;
    logic                rd_acc;
    logic                is_op;
    logic                is_ctrl;
    logic                is_stat;
    logic                is_cyc;
    logic                is_res;
    logic                ctrl_wr;
    logic                op_wr;

    logic [OP_LANES-1:0] op_we;
    logic [RES_WIDTH-1:0] res_q;
    logic [31:0]         res_lane;
    logic [31:0]         reg_rdata;
    logic [31:0]         status_w;
    logic                rd_pend;
    logic [1:0]          rd_lane;
    status_t             st;

    assign busy     = (state == ST_LAUNCH) || (state == ST_RUN);
    assign host_acc = host_valid && host_ready;
    assign wr_acc   = host_acc && host_we;
    assign rd_acc   = host_acc && !host_we;

    assign is_op   = host_addr <= OPRAM_LAST;
    assign is_ctrl = host_addr == CTRL_ADDR;
    assign is_stat = host_addr == STATUS_ADDR;
    assign is_cyc  = host_addr == CYCLES_ADDR;
    assign is_res  = host_addr >= RESRAM_BASE;

    assign ctrl_wr = wr_acc && is_ctrl;
    assign op_wr   = wr_acc && is_op;

    // Only one read may be in flight; back-pressure holds rdata.
    assign host_ready = !rd_pend && !(host_rvalid && !host_rready);

    always_comb begin
        op_we = '0;
        if (op_wr && !busy) begin
            op_we[host_addr[0]] = 1'b1;
        end
    end

    vmx_sdp_ram #(
        .WIDTH (OP_WIDTH),
        .DEPTH (2**ADDR_WIDTH),
        .LANES (OP_LANES),
        .AW    (ADDR_WIDTH)
    ) u_opram (
        .clk   (clk),
        .we    (op_we),
        .waddr (host_addr[8:1]),
        .wdata ({OP_LANES{host_wdata}}),
        .re    (1'b1),
        .raddr (eng_addr),
        .rdata (eng_op)
    );

    vmx_sdp_ram #(
        .WIDTH (RES_WIDTH),
        .DEPTH (2**ADDR_WIDTH),
        .LANES (RES_LANES),
        .AW    (ADDR_WIDTH)
    ) u_resram (
        .clk   (clk),
        .we    ({RES_LANES{eng_wr_en}}),
        .waddr (eng_addr),
        .wdata (eng_res),
        .re    (rd_acc && is_res),
        .raddr (host_addr[9:2]),
        .rdata (res_q)
    );

    always_comb begin
        st.busy          = busy;
        st.done          = done_q;
        st.timeout_err   = tmo_q;
        st.wr_reject_err = rej_q;
        st.state         = state;
        status_w         = pack_status(st);
    end

    always_comb begin
        reg_rdata = '0;
        unique case (1'b1)
            is_stat: reg_rdata = status_w;
            is_cyc:  reg_rdata = cycles;
            default: reg_rdata = '0;
        endcase
    end

    assign res_lane = res_q[{rd_lane, 5'd0} +: 32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend     <= 1'b0;
            rd_lane     <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            rd_pend <= rd_acc && is_res;
            if (rd_acc && is_res) begin
                rd_lane <= host_addr[1:0];
            end
            if (rd_acc && !is_res) begin
                host_rvalid <= 1'b1;
                host_rdata  <= reg_rdata;
            end else if (rd_pend) begin
                host_rvalid <= 1'b1;
                host_rdata  <= res_lane;
            end else if (host_rvalid && host_rready) begin
                host_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            simd_q <= 1'b0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            rej_q  <= 1'b0;
            cycles <= '0;
            lcnt   <= '0;
        end else begin
            if (ctrl_wr && host_wdata[CTRL_CLR]) begin
                done_q <= 1'b0;
                rej_q  <= 1'b0;
            end
            if (op_wr && busy) begin
                rej_q <= 1'b1;
            end
            if (busy && cycles != '1) begin
                cycles <= cycles + 32'd1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (ctrl_wr && host_wdata[CTRL_START]) begin
                        state  <= ST_LAUNCH;
                        simd_q <= host_wdata[CTRL_SIMD];
                        done_q <= 1'b0;
                        tmo_q  <= 1'b0;
                        cycles <= '0;
                        lcnt   <= '0;
                    end
                end
                ST_LAUNCH: begin
                    if (eng_flag != ENG_FLAG_IDLE) begin
                        state <= ST_RUN;
                    end else if (lcnt == TW'(LAUNCH_TIMEOUT - 1)) begin
                        tmo_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (eng_flag == ENG_FLAG_IDLE) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Launch is driven only while waiting for the engine to respond.
    always_comb begin
        eng_ctrl = '0;
        if (state == ST_LAUNCH) begin
            eng_ctrl[CTRL_START] = 1'b1;
            eng_ctrl[CTRL_SIMD]  = simd_q;
        end
    end

endmodule
